// File: rtl/add_sub_seq.sv
// add_sub_seq: chunk-serial adder/subtractor with valid/ready handshakes
module add_sub_seq #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = N > 1 ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic cy_q, cy_d, ovf_q, ovf_d;
  logic [CHUNK:0] slice;
  logic [WIDTH+CHUNK-1:0] cat;
  logic last;
  // operands shift right each cycle so the active slice is always the low CHUNK bits
  assign slice = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, cy_q};
  // new slice enters at the top; after N cycles the sum is fully aligned
  assign cat   = {slice[CHUNK-1:0], sum_q};
  assign last  = cnt_q == CW'(N - 1);
  // state and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      ovf_q   <= ovf_d;
    end
  end
  // next-state: capture in IDLE, one slice per BUSY cycle, hold in DONE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        a_d     = op1;
        b_d     = sub ? ~op2 : op2;
        cy_d    = sub;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        sum_d = cat[WIDTH+CHUNK-1:CHUNK];
        cy_d  = slice[CHUNK];
        cnt_d = cnt_q + CW'(1);
        if (last) begin
          // carry into MSB recovered from the MSB sum bit and its operands
          ovf_d   = slice[CHUNK] ^ slice[CHUNK-1] ^ a_q[CHUNK-1] ^ b_q[CHUNK-1];
          state_d = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign result    = out_valid ? sum_q : '0;
  assign carry     = out_valid && cy_q;
  assign overflow  = out_valid && ovf_q;
  assign zero      = out_valid && sum_q == '0;
  assign negative  = out_valid && sum_q[WIDTH-1];
endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: directed scoreboard bench for add_sub_seq
module tb_add_sub_seq;
  typedef struct packed {logic [31:0] r; logic c, v, z, n;} exp_t;
  logic clk = 0, rst_n = 0, in_valid = 0, in_valid_x = 0, sub = 0, out_ready = 1, ordy_x = 1;
  logic [31:0] op1 = 0, op2 = 0;
  logic in_ready, out_valid, carry, overflow, zero, negative;
  logic [31:0] result;
  logic ir32, ov32, c32, v32, z32, n32, ir1, ov1, c1, v1, z1, n1;
  logic [31:0] r32, r1;
  int total = 0, bad = 0, lat;
  exp_t sb[$];
  exp_t ea, e32, e1;
  add_sub_seq #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .op1(op1), .op2(op2),
    .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
    .overflow(overflow), .zero(zero), .negative(negative));
  add_sub_seq #(.WIDTH(32), .CHUNK(32)) d32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(ir32), .op1(op1), .op2(op2),
    .sub(sub), .out_valid(ov32), .out_ready(ordy_x), .result(r32), .carry(c32),
    .overflow(v32), .zero(z32), .negative(n32));
  add_sub_seq #(.WIDTH(32), .CHUNK(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_x), .in_ready(ir1), .op1(op1), .op2(op2),
    .sub(sub), .out_valid(ov1), .out_ready(ordy_x), .result(r1), .carry(c1),
    .overflow(v1), .zero(z1), .negative(n1));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic s);
    exp_t m;
    logic [32:0] t;
    logic [31:0] bb;
    bb = s ? ~b : b;
    t = {1'b0, a} + {1'b0, bb} + {32'b0, s};
    m.r = t[31:0];
    m.c = t[32];
    m.v = (a[31] == bb[31]) && (t[31] != a[31]);
    m.z = t[31:0] == 32'b0;
    m.n = t[31];
    return m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask
  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=output expected=none");
    end else begin
      e = sb.pop_front();
      chk("result", result, e.r);
      chk1("carry", carry, e.c);
      chk1("overflow", overflow, e.v);
      chk1("zero", zero, e.z);
      chk1("negative", negative, e.n);
    end
  endtask
  task automatic wait_done(input int exp_lat);
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    check_out();
  endtask
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    chk1("in_ready_idle", in_ready, 1'b1);
    op1 = a;
    op2 = b;
    sub = s;
    in_valid = 1;
    sb.push_back(model(a, b, s));
    @(negedge clk);
    in_valid = 0;
    chk1("in_ready_busy", in_ready, 1'b0);
    op1 = $urandom;
    op2 = $urandom;
    sub = ~s;
    wait_done(4);
    @(negedge clk);
    chk1("out_valid_after_hs", out_valid, 1'b0);
    chk("result_when_invalid", result, 32'h0);
  endtask
  logic [31:0] va[6] = '{32'h4, 32'h80000004, 32'h80000007, 32'h7, 32'hFFFFFFFF, 32'h7FFFFFFF};
  logic [31:0] vb[6] = '{32'h7, 32'h7, 32'h4, 32'h4, 32'h1, 32'h1};
  logic        vs[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  initial begin
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_result", result, 32'h0);
    chk1("rst_carry", carry, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1;
    for (int i = 0; i < 6; i++) run_op(va[i], vb[i], vs[i]);
    chk("spec_sub_lit", model(32'h4, 32'h7, 1'b1).r, 32'hFFFFFFFD);
    for (int i = 0; i < 8; i++) run_op($urandom, $urandom, 1'($urandom_range(0, 1)));
    run_op(32'h0, 32'h80000000, 1'b1);
    run_op(32'h0, 32'h0, 1'b1);
    out_ready = 0;
    op1 = 32'h80000004;
    op2 = 32'h7;
    sub = 1;
    in_valid = 1;
    ea = model(32'h80000004, 32'h7, 1'b1);
    sb.push_back(ea);
    @(negedge clk);
    op1 = 32'h12345678;
    op2 = 32'h11111111;
    sub = 0;
    wait_done(4);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk1("bp_out_valid", out_valid, 1'b1);
      chk("bp_result", result, ea.r);
      chk1("bp_carry", carry, ea.c);
      chk1("bp_overflow", overflow, ea.v);
      chk1("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1;
    @(negedge clk);
    chk1("bp_hs_out_valid", out_valid, 1'b0);
    chk1("bp_hs_in_ready", in_ready, 1'b1);
    sb.push_back(model(32'h12345678, 32'h11111111, 1'b0));
    @(negedge clk);
    in_valid = 0;
    chk1("bp_reaccept", in_ready, 1'b0);
    wait_done(4);
    @(negedge clk);
    op1 = 32'h4;
    op2 = 32'h7;
    sub = 1;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    chk1("rbusy_out_valid", out_valid, 1'b0);
    chk("rbusy_result", result, 32'h0);
    chk1("rbusy_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("rbusy_no_spurious", out_valid, 1'b0);
    end
    out_ready = 0;
    op1 = 32'hFFFFFFFF;
    op2 = 32'h1;
    sub = 0;
    in_valid = 1;
    @(negedge clk);
    in_valid = 0;
    lat = 0;
    while (!out_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk1("rdone_reached", out_valid, 1'b1);
    chk1("rdone_zero_before", zero, 1'b1);
    #2 rst_n = 0;
    #1;
    chk1("rdone_out_valid", out_valid, 1'b0);
    chk("rdone_result", result, 32'h0);
    chk1("rdone_carry", carry, 1'b0);
    chk1("rdone_zero", zero, 1'b0);
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("rdone_no_spurious", out_valid, 1'b0);
    end
    run_op(32'h7, 32'h4, 1'b1);
    op1 = 32'h4;
    op2 = 32'h7;
    sub = 1;
    in_valid_x = 1;
    e32 = '0;
    e1 = '0;
    @(negedge clk);
    in_valid_x = 0;
    begin
      int l32, l1;
      l32 = -1;
      l1 = -1;
      for (int k = 0; k <= 40; k++) begin
        if (ov32 && l32 < 0) begin
          l32 = k;
          e32 = '{r: r32, c: c32, v: v32, z: z32, n: n32};
        end
        if (ov1 && l1 < 0) begin
          l1 = k;
          e1 = '{r: r1, c: c1, v: v1, z: z1, n: n1};
        end
        @(negedge clk);
      end
      chk("c32_latency", l32, 1);
      chk("c1_latency", l1, 32);
    end
    ea = model(32'h4, 32'h7, 1'b1);
    chk("c32_out", {e32.r[27:0], e32.c, e32.v, e32.z, e32.n}, {ea.r[27:0], ea.c, ea.v, ea.z, ea.n});
    chk("c32_hi", {28'b0, e32.r[31:28]}, {28'b0, ea.r[31:28]});
    chk("c1_out", {e1.r[27:0], e1.c, e1.v, e1.z, e1.n}, {ea.r[27:0], ea.c, ea.v, ea.z, ea.n});
    chk("c1_hi", {28'b0, e1.r[31:28]}, {28'b0, ea.r[31:28]});
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
